// File: rtl/nios_2_button_poller.sv
// Avalon-MM master that polls a button PIO, debounces bit 0 across polls and
// toggles an LED PIO bit on every debounced press, without CPU involvement.
module nios_2_button_poller #(
  parameter int ADDR_W           = 4,
  parameter int BUTTON_ADDR      = 0,
  parameter int LED_ADDR         = 4,
  parameter int POLL_CYCLES      = 4,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter bit ACTIVE_LOW       = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              press_pulse,
  output logic              led_state
);

  localparam int TIMER_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(POLL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [7:0]         DS         = 8'(DEBOUNCE_SAMPLES);
  localparam logic [ADDR_W-1:0]  BTN_A      = ADDR_W'(BUTTON_ADDR);
  localparam logic [ADDR_W-1:0]  LED_A      = ADDR_W'(LED_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EVAL,
    S_WRITE
  } state_t;

  state_t             state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               pressed_reg;
  logic               last_reg;
  logic [7:0]         stable_cnt_reg;
  logic               debounced_reg;

  logic [7:0] cnt_next;
  logic       accept;
  logic       new_press;

  // Only bit 0 of the button register carries information.
  logic readdata_unused;
  assign readdata_unused = ^avm_readdata[31:1];

  // Run length of identical samples, saturating at the debounce threshold.
  always_comb begin
    cnt_next  = 8'd1;
    accept    = 1'b0;
    new_press = 1'b0;
    if (pressed_reg == last_reg) begin
      cnt_next = (stable_cnt_reg >= DS) ? DS : stable_cnt_reg + 8'd1;
    end
    if ((cnt_next == DS) && (pressed_reg != debounced_reg)) begin
      accept    = 1'b1;
      new_press = pressed_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      timer_reg      <= TIMER_LOAD;
      pressed_reg    <= 1'b0;
      last_reg       <= 1'b0;
      stable_cnt_reg <= 8'd0;
      debounced_reg  <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      press_pulse    <= 1'b0;
      led_state      <= 1'b0;
    end else begin
      // Bus strobes are single-cycle; each state re-asserts what it needs.
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      press_pulse   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (timer_reg == '0) begin
            state_reg   <= S_READ;
            avm_read    <= 1'b1;
            avm_address <= BTN_A;
          end else begin
            timer_reg <= timer_reg - TIMER_ONE;
          end
        end
        S_READ: begin
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // Slave returns data in this cycle (fixed latency 1).
          pressed_reg <= avm_readdata[0] ^ ACTIVE_LOW;
          state_reg   <= S_EVAL;
        end
        S_EVAL: begin
          stable_cnt_reg <= cnt_next;
          last_reg       <= pressed_reg;
          if (accept) begin
            debounced_reg <= pressed_reg;
          end
          if (new_press) begin
            led_state     <= ~led_state;
            state_reg     <= S_WRITE;
            avm_write     <= 1'b1;
            avm_address   <= LED_A;
            avm_writedata <= {31'b0, ~led_state};
            press_pulse   <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
            timer_reg <= TIMER_LOAD;
          end
        end
        S_WRITE: begin
          state_reg <= S_IDLE;
          timer_reg <= TIMER_LOAD;
        end
        default: begin
          state_reg <= S_IDLE;
          timer_reg <= TIMER_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_2_button_poller.sv
// Scoreboard bench for nios_2_button_poller: a poll-level debounce model pushes
// expected results per sample; a bus monitor pops them as each poll completes.
module tb_nios_2_button_poller;

  localparam int POLL = 4;
  localparam int DS   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        press_pulse, led_state;

  logic [3:0]  avm_address_6;
  logic        avm_read_6, avm_write_6;
  logic [31:0] avm_writedata_6, avm_readdata_6;
  logic        press_pulse_6, led_state_6;

  nios_2_button_poller #(
    .ADDR_W(4), .BUTTON_ADDR(0), .LED_ADDR(4), .POLL_CYCLES(POLL),
    .DEBOUNCE_SAMPLES(DS), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .press_pulse(press_pulse), .led_state(led_state)
  );

  nios_2_button_poller #(
    .ADDR_W(4), .BUTTON_ADDR(0), .LED_ADDR(4), .POLL_CYCLES(POLL),
    .DEBOUNCE_SAMPLES(1), .ACTIVE_LOW(1'b0)
  ) u_dut6 (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address_6),
    .avm_read(avm_read_6), .avm_write(avm_write_6), .avm_writedata(avm_writedata_6),
    .avm_readdata(avm_readdata_6), .press_pulse(press_pulse_6), .led_state(led_state_6)
  );

  typedef struct {
    bit wr;
    bit led;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb6_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Poll-level model: accept a level once the trailing DS samples agree on it.
  bit hist[$];
  bit m_deb = 1'b0;
  bit m_led = 1'b0;

  task automatic model_step(input bit pressed, output exp_t e);
    int run = 0;
    hist.push_back(pressed);
    for (int i = hist.size() - 1; i >= 0 && run < DS; i--) begin
      if (hist[i] != pressed) break;
      run++;
    end
    e.wr = 1'b0;
    if (run == DS && pressed != m_deb) begin
      m_deb = pressed;
      if (pressed) begin
        m_led = ~m_led;
        e.wr  = 1'b1;
      end
    end
    e.led = m_led;
  endtask

  // Bus monitor for u_dut.
  int   cyc = 0, last_rd = 0, phase = 0, polls_done = 0, exp_period = POLL + 3;
  bit   have_prev = 1'b0;
  bit   mon_en = 1'b1;
  exp_t e_mon;

  always @(negedge clk) begin
    if (!reset_n) begin
      cyc       = 0;
      have_prev = 1'b0;
      phase     = 0;
    end else if (mon_en) begin
      cyc++;
      if (avm_read) begin
        if (have_prev) check("poll_period", cyc - last_rd, exp_period);
        else check("first_read_cycle", cyc, POLL + 1);
        check("read_addr", avm_address, 0);
        check("read_midpoll", phase, 0);
        have_prev = 1'b1;
        last_rd   = cyc;
        phase     = 1;
      end else begin
        if (phase != 0) phase++;
        if (phase == 4) begin
          check("sb_pending", sb_q.size(), 1);
          if (sb_q.size() != 0) begin
            e_mon = sb_q.pop_front();
            check("write_strobe", avm_write, e_mon.wr);
            check("press_pulse", press_pulse, e_mon.wr);
            check("led_state", led_state, e_mon.led);
            if (e_mon.wr) begin
              check("write_addr", avm_address, 4);
              check("writedata", avm_writedata, {31'b0, e_mon.led});
            end
            exp_period = e_mon.wr ? POLL + 4 : POLL + 3;
          end
          phase = 0;
          polls_done++;
        end else begin
          check("quiet_ctrl", {avm_write, press_pulse, avm_address}, 0);
          check("quiet_wdata", avm_writedata, 0);
        end
      end
    end
  end

  task automatic apply(input logic [31:0] rd, input bit wait_done);
    exp_t e;
    int   start;
    model_step(rd[0] ^ 1'b1, e);
    avm_readdata = rd;
    sb_q.push_back(e);
    if (wait_done) begin
      start = polls_done;
      for (int k = 0; k < 40 && polls_done == start; k++) @(negedge clk);
      check("poll_timeout", polls_done - start, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e6;
    int   n;
    bit   wr_seen;

    reset_n        = 1'b0;
    avm_readdata   = 32'h1;
    avm_readdata_6 = 32'h0;
    repeat (3) @(negedge clk);

    // T1: outputs held at zero during reset
    check("rst_ctrl", {avm_read, avm_write, press_pulse, led_state, avm_address}, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_ctrl6", {avm_read_6, avm_write_6, press_pulse_6, led_state_6, avm_address_6}, 0);
    check("rst_wdata6", avm_writedata_6, 0);
    @(posedge clk); #2 reset_n = 1'b1;

    // T2: released, T3: pressed and held
    repeat (10) apply(32'h1, 1'b1);
    repeat (10) apply(32'h0, 1'b1);
    // T5: debounced release, then re-press with junk in upper bits
    repeat (3) apply(32'h1, 1'b1);
    repeat (3) apply(32'hFFFF_FFFE, 1'b1);
    // T4: bouncing press after a clean release
    repeat (3) apply(32'h1, 1'b1);
    apply(32'h0, 1'b1);
    apply(32'h1, 1'b1);
    apply(32'h0, 1'b1);
    apply(32'h0, 1'b1);
    apply(32'h0, 1'b0);

    // T1: async reset in the middle of the resulting WRITE
    for (int k = 0; k < 40 && !avm_write; k++) @(negedge clk);
    check("mid_write_seen", avm_write, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_write", avm_write, 0);
    check("async_rst_led", led_state, 0);
    check("async_rst_pulse", press_pulse, 0);
    check("async_rst_addr", avm_address, 0);
    sb_q.delete();
    hist.delete();
    m_deb = 1'b0;
    m_led = 1'b0;
    @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) apply(32'h1, 1'b1);
    mon_en = 1'b0;

    // T6: DEBOUNCE_SAMPLES=1, ACTIVE_LOW=0, sample 0 -> 1
    for (int k = 0; k < 40 && !avm_read_6; k++) @(negedge clk);
    check("t6_read_seen", avm_read_6, 1);
    avm_readdata_6 = 32'h1;
    sb6_q.push_back('{wr: 1'b1, led: 1'b1});
    n = 0;
    for (int k = 0; k < 20 && !avm_write_6; k++) begin
      @(negedge clk);
      n++;
    end
    check("t6_write_latency", n, 3);
    check("t6_sb_pending", sb6_q.size(), 1);
    if (sb6_q.size() != 0) begin
      e6 = sb6_q.pop_front();
      check("t6_write", avm_write_6, e6.wr);
      check("t6_addr", avm_address_6, 4);
      check("t6_wdata", avm_writedata_6, {31'b0, e6.led});
      check("t6_pulse", press_pulse_6, e6.wr);
      check("t6_led", led_state_6, e6.led);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (avm_read_6) break;
    end
    check("t6_period_write", n, POLL + 4);

    // held high: no repeat toggle
    sb6_q.push_back('{wr: 1'b0, led: 1'b1});
    n       = 0;
    wr_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (avm_write_6) wr_seen = 1'b1;
      if (avm_read_6) break;
    end
    check("t6_sb_pending2", sb6_q.size(), 1);
    if (sb6_q.size() != 0) begin
      e6 = sb6_q.pop_front();
      check("t6_held_write", wr_seen, e6.wr);
      check("t6_held_led", led_state_6, e6.led);
    end
    check("t6_period_idle", n, POLL + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
